// File: rtl/prio_encoder_reg.sv
// Registered N-to-log2(N) priority encoder with fixed (highest index) or round-robin priority.
// Latency: 1 cycle from an input transfer to out_valid with its result.
// Backpressure: in_ready = !out_valid || out_ready; a stalled result holds and din is ignored.
module prio_encoder_reg #(
    parameter int  N           = 8,
    parameter int  ROUND_ROBIN = 0,
    localparam int W           = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] dout,
    output logic         none,
    output logic         multi,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] rr_ptr;
    logic [W-1:0] cand;
    logic [W-1:0] fix_idx;
    logic [W-1:0] lo_idx;
    logic [W-1:0] hi_idx;
    logic         hi_found;
    logic [W-1:0] win_idx;
    logic         none_c;
    logic         multi_c;
    logic         in_xfer;
    logic         out_xfer;

    assign in_ready = !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    assign none_c  = (din == '0);
    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign multi_c = |(din & (din - N'(1)));

    // Round-robin order rr_ptr+1 .. rr_ptr+N is the lowest set index above rr_ptr,
    // or, failing that, the lowest set index overall (the wrapped part of the search).
    always_comb begin
        cand     = '0;
        fix_idx  = '0;
        lo_idx   = '0;
        hi_idx   = '0;
        hi_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = W'(i);
            if (din[cand]) begin
                fix_idx = cand;
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            cand = W'(i);
            if (din[cand]) begin
                lo_idx = cand;
                if (cand > rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        win_idx = '0;
        if (!none_c) begin
            if (ROUND_ROBIN != 0) begin
                win_idx = hi_found ? hi_idx : lo_idx;
            end else begin
                win_idx = fix_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            dout      <= '0;
            none      <= 1'b0;
            multi     <= 1'b0;
            rr_ptr    <= W'(N - 1);
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            dout      <= win_idx;
            none      <= none_c;
            multi     <= multi_c;
            if (ROUND_ROBIN != 0 && !none_c) begin
                rr_ptr <= win_idx;
            end
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prio_encoder_reg.sv
// Bench for prio_encoder_reg: fixed N=8, round-robin N=8 and round-robin N=5 instances
// driven in lockstep and compared against a behavioural model.
module tb_prio_encoder_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] din;

    logic       a_ir[3];
    logic       a_ov[3];
    logic [2:0] a_dout[3];
    logic       a_none[3];
    logic       a_multi[3];

    int total = 0;
    int bad   = 0;

    // model state: unit 0 fixed N=8, unit 1 rr N=8, unit 2 rr N=5
    int nn[3] = '{8, 8, 5};
    bit rrm[3] = '{1'b0, 1'b1, 1'b1};
    bit m_vld;
    int e_dout[3];
    int e_none[3];
    int e_multi[3];
    int ptr[3];

    always #5 clk = ~clk;

    prio_encoder_reg #(.N(8), .ROUND_ROBIN(0)) u_fix (
        .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(a_ir[0]),
        .dout(a_dout[0]), .none(a_none[0]), .multi(a_multi[0]),
        .out_valid(a_ov[0]), .out_ready(out_ready)
    );
    prio_encoder_reg #(.N(8), .ROUND_ROBIN(1)) u_rr8 (
        .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(a_ir[1]),
        .dout(a_dout[1]), .none(a_none[1]), .multi(a_multi[1]),
        .out_valid(a_ov[1]), .out_ready(out_ready)
    );
    prio_encoder_reg #(.N(5), .ROUND_ROBIN(1)) u_rr5 (
        .clk(clk), .rst(rst), .din(din[4:0]), .in_valid(in_valid), .in_ready(a_ir[2]),
        .dout(a_dout[2]), .none(a_none[2]), .multi(a_multi[2]),
        .out_valid(a_ov[2]), .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int popc(input int v);
        int c = 0;
        while (v != 0) begin
            c += v & 1;
            v = v >> 1;
        end
        return c;
    endfunction

    function automatic int winner(input int v, input int n, input bit rr, input int p);
        int w = 0;
        if (v == 0) return 0;
        if (!rr) begin
            while (v > 1) begin
                v = v >> 1;
                w++;
            end
            return w;
        end
        for (int k = 1; k <= n; k++) begin
            int i = (p + k) % n;
            if (((v >> i) & 1) != 0) return i;
        end
        return 0;
    endfunction

    // One clock: check in_ready, advance the model, then check registered outputs.
    task automatic tick();
        bit xin;
        bit xout;
        int v;
        #1;
        for (int u = 0; u < 3; u++) check($sformatf("in_ready%0d", u), a_ir[u], !m_vld || out_ready);
        xin  = !rst && in_valid && (!m_vld || out_ready);
        xout = !rst && m_vld && out_ready;
        if (rst) begin
            m_vld = 1'b0;
            for (int u = 0; u < 3; u++) begin
                e_dout[u] = 0; e_none[u] = 0; e_multi[u] = 0; ptr[u] = nn[u] - 1;
            end
        end else if (xin) begin
            m_vld = 1'b1;
            for (int u = 0; u < 3; u++) begin
                v = int'(din) % (1 << nn[u]);
                e_none[u]  = (v == 0);
                e_multi[u] = (popc(v) > 1);
                e_dout[u]  = winner(v, nn[u], rrm[u], ptr[u]);
                if (rrm[u] && v != 0) ptr[u] = e_dout[u];
            end
        end else if (xout) begin
            m_vld = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            check($sformatf("out_valid%0d", u), a_ov[u], m_vld);
            if (m_vld) begin
                check($sformatf("dout%0d", u), a_dout[u], e_dout[u]);
                check($sformatf("none%0d", u), a_none[u], e_none[u]);
                check($sformatf("multi%0d", u), a_multi[u], e_multi[u]);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; din = 8'hFF; out_ready = 1'b1; m_vld = 1'b0;
        for (int u = 0; u < 3; u++) begin
            e_dout[u] = 0; e_none[u] = 0; e_multi[u] = 0; ptr[u] = nn[u] - 1;
        end
        @(posedge clk);
        #1;
        // reset held with a valid all-ones request
        tick();
        tick();
        for (int u = 0; u < 3; u++) begin
            check($sformatf("rst_ov%0d", u), a_ov[u], 1'b0);
            check($sformatf("rst_dout%0d", u), a_dout[u], 3'd0);
            check($sformatf("rst_none%0d", u), a_none[u], 1'b0);
            check($sformatf("rst_multi%0d", u), a_multi[u], 1'b0);
        end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("rel_in_ready", a_ir[0], 1'b1);

        // single one-hot request
        in_valid = 1'b1; din = 8'b0000_0100;
        tick();
        check("onehot_dout", a_dout[0], 3'd2);
        in_valid = 1'b0;
        tick();

        // back-to-back multi-hot then zero
        in_valid = 1'b1; din = 8'b0110_0000;
        tick();
        check("b2b_dout", a_dout[0], 3'd6);
        check("b2b_multi", a_multi[0], 1'b1);
        din = 8'h00;
        tick();
        check("b2b_ov", a_ov[0], 1'b1);
        check("b2b_none", a_none[0], 1'b1);
        check("b2b_dout0", a_dout[0], 3'd0);

        // round-robin rotation from reset
        do_reset();
        din = 8'b1000_0101;
        tick(); check("rr_seq0", a_dout[1], 3'd0);
        tick(); check("rr_seq1", a_dout[1], 3'd2);
        tick(); check("rr_seq2", a_dout[1], 3'd7);
        tick(); check("rr_seq3", a_dout[1], 3'd0);
        tick(); check("rr_seq4", a_dout[1], 3'd2);
        din = 8'h00;
        tick(); check("rr_none", a_none[1], 1'b1);
        din = 8'hFF;
        tick(); check("rr_resume", a_dout[1], 3'd3);

        // backpressure holds the result while din changes
        din = 8'b0000_1000;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din = 8'($urandom);
            tick();
            check("stall_dout", a_dout[0], 3'd3);
        end
        out_ready = 1'b1; din = 8'b0001_0000;
        tick();
        check("unstall_dout", a_dout[0], 3'd4);

        // reset during a stall drops the pending result
        out_ready = 1'b0; din = 8'h81;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_stall_ov", a_ov[0], 1'b0);
        rst = 1'b0; out_ready = 1'b1;

        // N=5 round robin alternates between its two set lines
        do_reset();
        din = 8'b0001_0001;
        tick(); check("n5_seq0", a_dout[2], 3'd0);
        tick(); check("n5_seq1", a_dout[2], 3'd4);
        tick(); check("n5_seq2", a_dout[2], 3'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            din       = 8'($urandom);
            if ($urandom_range(0, 3) == 0) din = 8'h00;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
